lsu: RTL and testbench

Load/store unit for the single-cycle RV32I core. It takes the decoded memory-instruction class, effective address and store data from the execute stage, and runs a req/ack transaction on the data-memory bus. It returns the aligned, extended load result for register write-back. While the transaction is outstanding it holds the core with `stall`, which freezes the PC and suppresses the register-file write.

---
 rtl/lsu.sv | 218 +++++++++++++++++++++
 tb/tb_lsu.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: RV32I load/store unit running one req/ack data-memory transaction per memory instruction.
// Optional macro LSU_MISALIGN_CHECK_EN: fault misaligned half/word accesses instead of truncating them.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

    localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  alo_q, alo_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        legal_s;
    logic        misalign_s;
    logic [3:0]  strb_s;
    logic [31:0] wpos_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] ext_s;

    // Decode the incoming instruction: legality, alignment and store lane placement
    always_comb begin
        legal_s = 1'b0;
        if (load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
                default:                                legal_s = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: legal_s = 1'b1;
                default:                legal_s = 1'b0;
            endcase
        end
`ifdef LSU_MISALIGN_CHECK_EN
        misalign_s = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        if (load) begin
            strb_s = 4'b0000;
            wpos_s = 32'd0;
        end else begin
            case (funct3[1:0])
                2'b00: begin
                    strb_s = 4'b0001 << addr[1:0];
                    wpos_s = {4{wdata[7:0]}};
                end
                2'b01: begin
                    strb_s = 4'b0011 << {addr[1], 1'b0};
                    wpos_s = {2{wdata[15:0]}};
                end
                default: begin
                    strb_s = 4'b1111;
                    wpos_s = wdata;
                end
            endcase
        end
    end

    // Extract and extend the addressed lane of the returned read word
    always_comb begin
        case (alo_q)
            2'b00:   byte_s = mem_rdata[7:0];
            2'b01:   byte_s = mem_rdata[15:8];
            2'b10:   byte_s = mem_rdata[23:16];
            default: byte_s = mem_rdata[31:24];
        endcase
        if (alo_q[1]) begin
            half_s = mem_rdata[31:16];
        end else begin
            half_s = mem_rdata[15:0];
        end
        case (f3_q[1:0])
            2'b00:   ext_s = f3_q[2] ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
            2'b01:   ext_s = f3_q[2] ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
            default: ext_s = mem_rdata;
        endcase
    end

    // Next-state and next-output logic; bus fields are cleared whenever BUS is left
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_load_d   = is_load_q;
        f3_d        = f3_q;
        alo_d       = alo_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        rdata_d     = 32'd0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (load || store) begin
                    is_load_d = load;
                    f3_d      = funct3;
                    alo_d     = addr[1:0];
                    cnt_d     = 32'd0;
                    if (legal_s && !misalign_s) begin
                        state_d     = BUS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = !load;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wstrb_d = strb_s;
                        mem_wdata_d = wpos_s;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (mem_ack || ((TO_LIM != 32'd0) && ((cnt_q + 32'd1) == TO_LIM))) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    fault_d     = !mem_ack;
                    rdata_d     = (mem_ack && is_load_q) ? ext_s : 32'd0;
                    cnt_d       = 32'd0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'd0;
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched instruction fields and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 32'd0;
            is_load_q   <= 1'b0;
            f3_q        <= 3'd0;
            alo_q       <= 2'd0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_load_q   <= is_load_d;
            f3_q        <= f3_d;
            alo_q       <= alo_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign stall     = ((state_q == IDLE) && (load || store)) || (state_q == BUS);
    assign done      = done_q;
    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard testbench for lsu: a byte-level reference model predicts each access's bus fields and result.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        load, store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, fault;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        load_t, store_t, ack_t;
    logic        stall_t, done_t, fault_t, mem_req_t, mem_we_t;
    logic [31:0] rdata_t, mem_addr_t, mem_wdata_t;
    logic [3:0]  mem_wstrb_t;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        fault;
        logic        bus;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  strb;
        logic [31:0] wdat;
        logic [31:0] rdat;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    lsu u_dut (
        .clk(clk), .rst(rst), .load(load), .store(store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
        .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    lsu #(.TIMEOUT(4)) u_to (
        .clk(clk), .rst(rst), .load(load_t), .store(store_t), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall_t), .done(done_t), .rdata(rdata_t),
        .fault(fault_t), .mem_req(mem_req_t), .mem_we(mem_we_t), .mem_addr(mem_addr_t),
        .mem_wstrb(mem_wstrb_t), .mem_wdata(mem_wdata_t), .mem_ack(ack_t),
        .mem_rdata(mem_rdata)
    );

    // Reference model working byte by byte over the access size.
    function automatic exp_t model(input logic is_ld, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rword);
        exp_t e;
        int sz;
        int lane;
        logic [31:0] v;
        e = '0;
        case (f3)
            3'd0: sz = 1;
            3'd1: sz = 2;
            3'd2: sz = 4;
            3'd4: sz = is_ld ? 1 : 0;
            3'd5: sz = is_ld ? 2 : 0;
            default: sz = 0;
        endcase
        if (sz == 0) begin
            e.fault = 1'b1;
            return e;
        end
        lane = int'(a[1:0]);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((lane % sz) != 0) begin
            e.fault = 1'b1;
            return e;
        end
`else
        lane = (lane / sz) * sz;
`endif
        e.bus   = 1'b1;
        e.we    = !is_ld;
        e.maddr = a & 32'hFFFF_FFFC;
        if (is_ld) begin
            v = rword >> (8 * lane);
            if (sz == 1) begin
                v = v & 32'h0000_00FF;
                if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2) begin
                v = v & 32'h0000_FFFF;
                if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            e.rdat = v;
        end else begin
            for (int b = 0; b < 4; b++) begin
                e.strb[b] = (b >= lane) && (b < lane + sz);
                e.wdat[8*b +: 8] = wd[8*(b % sz) +: 8];
            end
        end
        return e;
    endfunction

    // Drives one access at the current negedge and leaves at the negedge of the IDLE cycle after done.
    task automatic run_access(input logic is_ld, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int ack_dly, input logic [31:0] rword,
                              input string nm);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   seen;
        e = model(is_ld, f3, a, wd, rword);
        exp_q.push_back(e);
        load = is_ld; store = !is_ld; funct3 = f3; addr = a; wdata = wd;
        mem_ack = 1'b0; mem_rdata = rword;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL %s.stall_c0: got %b expected 1", nm, stall); end
        cyc = 0; seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (done === 1'b1) begin
                seen = 1;
                got = exp_q.pop_front();
                load = 1'b0; store = 1'b0;
                checks++;
                if (cyc != (got.bus ? ack_dly + 2 : 1)) begin
                    failures++; $display("FAIL %s.latency: got %0d expected %0d", nm, cyc, got.bus ? ack_dly + 2 : 1);
                end
                checks++;
                if (fault !== got.fault) begin failures++; $display("FAIL %s.fault: got %b expected %b", nm, fault, got.fault); end
                checks++;
                if (rdata !== got.rdat) begin failures++; $display("FAIL %s.rdata: got %h expected %h", nm, rdata, got.rdat); end
                checks++;
                if (stall !== 1'b0 || mem_req !== 1'b0) begin
                    failures++; $display("FAIL %s.done_cycle: got stall=%b req=%b expected 0 0", nm, stall, mem_req);
                end
            end else begin
                checks++;
                if (stall !== 1'b1 || mem_req !== e.bus) begin
                    failures++; $display("FAIL %s.wait_c%0d: got stall=%b req=%b expected 1 %b", nm, cyc, stall, mem_req, e.bus);
                end
                if (e.bus) begin
                    checks++;
                    if (mem_addr !== e.maddr || mem_wstrb !== e.strb || mem_we !== e.we || mem_wdata !== e.wdat) begin
                        failures++;
                        $display("FAIL %s.bus_c%0d: got addr=%h strb=%b we=%b wd=%h expected addr=%h strb=%b we=%b wd=%h",
                                 nm, cyc, mem_addr, mem_wstrb, mem_we, mem_wdata, e.maddr, e.strb, e.we, e.wdat);
                    end
                end
                if (cyc == ack_dly + 1) mem_ack = 1'b1;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s.done_timeout: got no done expected done within 40 cycles", nm);
            void'(exp_q.pop_front());
            load = 1'b0; store = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL %s.single_pulse: got done=%b expected 0", nm, done); end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0; load_t = 1'b0; store_t = 1'b0; ack_t = 1'b0;
        #12;
        checks++;
        if ({stall, done, fault, mem_req, mem_we} !== 5'b0 || rdata !== 32'd0 || mem_addr !== 32'd0 ||
            mem_wstrb !== 4'd0 || mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset: got stall=%b done=%b fault=%b req=%b we=%b rdata=%h addr=%h strb=%b wd=%h expected all 0",
                     stall, done, fault, mem_req, mem_we, rdata, mem_addr, mem_wstrb, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        run_access(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'd0, "sw");
        run_access(1'b0, 3'b000, 32'h0000_0203, 32'h1234_5678, 0, 32'd0, "sb");
        run_access(1'b0, 3'b001, 32'h0000_0102, 32'hCAFE_F00D, 1, 32'd0, "sh");
    endtask

    task automatic test_load();
        run_access(1'b1, 3'b000, 32'h0000_0101, 32'd0, 0, 32'h0000_8000, "lb");
        run_access(1'b1, 3'b100, 32'h0000_0101, 32'd0, 0, 32'h0000_8000, "lbu");
        run_access(1'b1, 3'b101, 32'h0000_0102, 32'd0, 0, 32'hBEEF_0000, "lhu");
        run_access(1'b1, 3'b001, 32'h0000_0100, 32'd0, 2, 32'h1234_8001, "lh");
        run_access(1'b1, 3'b010, 32'h0000_0104, 32'd0, 0, 32'hA5A5_5A5A, "lw");
    endtask

    task automatic test_delayed_ack();
        run_access(1'b1, 3'b010, 32'h0000_0200, 32'd0, 5, 32'h0BAD_F00D, "lw_delay5");
    endtask

    task automatic test_illegal();
        run_access(1'b1, 3'b011, 32'h0000_0100, 32'd0, 0, 32'hFFFF_FFFF, "ld_f3_011");
        run_access(1'b0, 3'b100, 32'h0000_0100, 32'h1111_1111, 0, 32'd0, "st_f3_100");
        run_access(1'b1, 3'b110, 32'h0000_0100, 32'd0, 0, 32'd0, "ld_f3_110");
    endtask

    task automatic test_misalign();
        run_access(1'b1, 3'b010, 32'h0000_0102, 32'd0, 0, 32'h1122_3344, "lw_mis");
        run_access(1'b0, 3'b001, 32'h0000_0101, 32'h0000_ABCD, 0, 32'd0, "sh_mis");
        run_access(1'b1, 3'b101, 32'h0000_0103, 32'd0, 0, 32'h8899_7766, "lhu_mis");
    endtask

    task automatic test_back_to_back();
        logic [2:0] ld_f3 [5];
        logic       is_ld;
        logic [2:0] f3;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 10; i++) begin
            is_ld = 1'($urandom_range(0, 1));
            f3 = is_ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            run_access(is_ld, f3, 32'h0000_1000 + 32'($urandom_range(0, 63)), 32'($urandom),
                       int'($urandom_range(0, 3)), 32'($urandom), "b2b");
        end
    endtask

    task automatic test_timeout();
        int  cyc;
        bit  seen;
        load_t = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300; ack_t = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (done_t === 1'b1) begin
                seen = 1;
                load_t = 1'b0;
                checks++;
                if (fault_t !== 1'b1 || rdata_t !== 32'd0 || cyc != 5) begin
                    failures++;
                    $display("FAIL timeout.done: got fault=%b rdata=%h cycle=%0d expected 1 00000000 5", fault_t, rdata_t, cyc);
                end
            end
        end
        if (!seen) begin
            checks++; failures++; load_t = 1'b0;
            $display("FAIL timeout.no_done: got no done expected done within 30 cycles");
        end
        @(negedge clk);
        checks++;
        if (mem_req_t !== 1'b0 || done_t !== 1'b0) begin
            failures++; $display("FAIL timeout.after: got req=%b done=%b expected 0 0", mem_req_t, done_t);
        end
    endtask

    task automatic test_reset_mid_bus();
        load = 1'b1; store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_bus.req_before: got %b expected 1", mem_req); end
        load = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL rst_bus.async: got req=%b stall=%b done=%b expected 0 0 0", mem_req, stall, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done !== 1'b0 || mem_req !== 1'b0) begin
                failures++; $display("FAIL rst_bus.late_ack: got done=%b req=%b expected 0 0", done, mem_req);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_delayed_ack();
        test_illegal();
        test_misalign();
        test_back_to_back();
        test_timeout();
        test_reset_mid_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
